// File: rtl/status_register_file_rmw.sv
// Parametrised status/config register file with atomic READ/WRITE/SET/CLEAR,
// sticky per-bit hardware events and a registered 1-cycle response path.
module status_register_file_rmw #(
  parameter int WORD_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 6,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic [TAG_WIDTH-1:0]           i_tag,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic [WORD_WIDTH-1:0]          i_data,
  input  logic [1:0]                     i_op,
  input  logic                           i_valid,
  input  logic                           i_halt,
  input  logic [NUM_REGS*WORD_WIDTH-1:0] i_hw_set,
  output logic [TAG_WIDTH-1:0]           o_tag,
  output logic [WORD_WIDTH-1:0]          o_data,
  output logic                           o_valid,
  output logic                           o_err,
  output logic                           o_freeze_inputs,
  output logic [NUM_REGS*WORD_WIDTH-1:0] o_status
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic                  accept;
  logic                  in_range;
  logic [WORD_WIDTH-1:0] rd_data;

  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;

  assign accept          = i_valid & ~i_halt;
  // One extra bit so NUM_REGS == 2**ADDR_WIDTH still compares correctly.
  assign in_range        = ({1'b0, i_addr} < (ADDR_WIDTH+1)'(NUM_REGS));
  assign o_freeze_inputs = i_halt;

  // Prior value read from the registered contents; same-cycle hw sets excluded.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (i_addr == ADDR_WIDTH'(r)) begin
        rd_data = o_status[r*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [WORD_WIDTH-1:0] reg_q, reg_d, hw;
    logic                  sel;

    assign hw  = i_hw_set[gi*WORD_WIDTH +: WORD_WIDTH];
    assign sel = accept && in_range && (i_addr == ADDR_WIDTH'(gi));

    // hw is OR-ed last in every branch so an event beats WRITE/CLEAR.
    always_comb begin
      reg_d = reg_q | hw;
      if (sel) begin
        case (i_op)
          OP_READ:  reg_d = reg_q | hw;
          OP_WRITE: reg_d = i_data | hw;
          OP_SET:   reg_d = reg_q | i_data | hw;
          OP_CLEAR: reg_d = (reg_q & ~i_data) | hw;
        endcase
      end
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign o_status[gi*WORD_WIDTH +: WORD_WIDTH] = reg_q;
  end

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (!i_halt) begin
      valid_d = i_valid;
      if (i_valid) begin
        tag_d  = i_tag;
        data_d = in_range ? rd_data : '0;
        err_d  = ~in_range;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_tag   = tag_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_status_register_file_rmw.sv
// Directed bench for status_register_file_rmw: stimulus pushes expected
// responses into a queue, an independent monitor pops and compares them.
module tb_status_register_file_rmw;

  localparam int W  = 12;
  localparam int AW = 3;
  localparam int NR = 6;
  localparam int TW = 1;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] CL = 2'b11;

  logic            clk = 1'b0;
  logic            arst_n;
  logic [TW-1:0]   i_tag;
  logic [AW-1:0]   i_addr;
  logic [W-1:0]    i_data;
  logic [1:0]      i_op;
  logic            i_valid;
  logic            i_halt;
  logic [NR*W-1:0] i_hw_set;
  logic [TW-1:0]   o_tag;
  logic [W-1:0]    o_data;
  logic            o_valid;
  logic            o_err;
  logic            o_freeze_inputs;
  logic [NR*W-1:0] o_status;

  status_register_file_rmw #(
    .WORD_WIDTH(W), .ADDR_WIDTH(AW), .NUM_REGS(NR), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .arst_n(arst_n), .i_tag(i_tag), .i_addr(i_addr),
    .i_data(i_data), .i_op(i_op), .i_valid(i_valid), .i_halt(i_halt),
    .i_hw_set(i_hw_set), .o_tag(o_tag), .o_data(o_data), .o_valid(o_valid),
    .o_err(o_err), .o_freeze_inputs(o_freeze_inputs), .o_status(o_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
    logic          err;
  } resp_t;

  resp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] reg_of(input int r);
    return o_status[r*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] data,
                     input logic [TW-1:0] tag, input logic [W-1:0] exp_data, input logic exp_err);
    resp_t e;
    i_valid = 1'b1;
    i_halt  = 1'b0;
    i_op    = op;
    i_addr  = addr;
    i_data  = data;
    i_tag   = tag;
    e.tag   = tag;
    e.data  = exp_data;
    e.err   = exp_err;
    exp_q.push_back(e);
    step();
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_halt  = 1'b0;
    step();
  endtask

  // Monitor: a response is due on every edge where the handshake was taken.
  initial begin
    resp_t e;
    logic  acc;
    forever begin
      @(posedge clk);
      acc = (arst_n === 1'b1) && (i_valid === 1'b1) && (i_halt === 1'b0);
      @(negedge clk);
      if (acc) begin
        check("o_valid", 32'(o_valid), 32'd1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got data 0x%0h, required no response", o_data);
        end else begin
          e = exp_q.pop_front();
          check("o_tag", 32'(o_tag), 32'(e.tag));
          check("o_data", 32'(o_data), 32'(e.data));
          check("o_err", 32'(o_err), 32'(e.err));
          $display("resp tag=%0d data=0x%03h err=%0d (exp data=0x%03h err=%0d)",
                   o_tag, o_data, o_err, e.data, e.err);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n   = 1'b0;
    i_tag    = '0;
    i_addr   = '0;
    i_data   = '0;
    i_op     = RD;
    i_valid  = 1'b0;
    i_halt   = 1'b0;
    i_hw_set = '0;
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_data", 32'(o_data), 32'd0);
    check("rst_o_err", 32'(o_err), 32'd0);
    check("rst_status_r0", 32'(reg_of(0)), 32'd0);
    step();
    step();
    arst_n = 1'b1;
    step();

    // Read of a freshly reset register, tag echoed.
    req(RD, 3'd2, 12'h000, 1'b1, 12'h000, 1'b0);
    // WRITE returns the old value; READ then sees the new one.
    req(WR, 3'd1, 12'hA5C, 1'b0, 12'h000, 1'b0);
    req(RD, 3'd1, 12'h000, 1'b1, 12'hA5C, 1'b0);
    check("status_r1", 32'(reg_of(1)), 32'hA5C);

    // SET / CLEAR with a concurrent hardware event that must win.
    req(WR, 3'd3, 12'h0F0, 1'b0, 12'h000, 1'b0);
    req(ST, 3'd3, 12'h00F, 1'b1, 12'h0F0, 1'b0);
    check("status_r3_set", 32'(reg_of(3)), 32'h0FF);
    i_hw_set[3*W +: W] = 12'h010;
    req(CL, 3'd3, 12'h0F0, 1'b0, 12'h0FF, 1'b0);
    i_hw_set = '0;
    check("status_r3_clr", 32'(reg_of(3)), 32'h01F);
    req(RD, 3'd3, 12'h000, 1'b1, 12'h01F, 1'b0);

    // Halt for three cycles with a pending WRITE and a hw event on reg 0.
    i_halt  = 1'b1;
    i_valid = 1'b1;
    i_op    = WR;
    i_addr  = 3'd0;
    i_data  = 12'h123;
    i_tag   = 1'b0;
    i_hw_set[0] = 1'b1;
    step();
    i_hw_set = '0;
    for (int k = 0; k < 3; k++) begin
      check("halt_freeze", 32'(o_freeze_inputs), 32'd1);
      check("halt_o_valid", 32'(o_valid), 32'd1);
      check("halt_o_data", 32'(o_data), 32'h01F);
      check("halt_o_tag", 32'(o_tag), 32'd1);
      check("halt_status_r0", 32'(reg_of(0)), 32'h001);
      if (k < 2) step();
    end
    req(WR, 3'd0, 12'h123, 1'b0, 12'h001, 1'b0);
    check("freeze_released", 32'(o_freeze_inputs), 32'd0);
    check("status_r0_wr", 32'(reg_of(0)), 32'h123);

    // Out-of-range write: error response, nothing modified.
    req(WR, 3'd7, 12'hFFF, 1'b1, 12'h000, 1'b1);
    idle();
    check("idle_o_valid", 32'(o_valid), 32'd0);
    check("idle_o_err_hold", 32'(o_err), 32'd1);
    check("oor_status", 32'(o_status),
          {12'h000, 12'h000, 12'h01F, 12'h000, 12'hA5C, 12'h123});

    // First illegal address, then the highest legal one.
    req(RD, 3'd6, 12'h000, 1'b0, 12'h000, 1'b1);
    req(WR, 3'd5, 12'h800, 1'b1, 12'h000, 1'b0);
    req(RD, 3'd5, 12'h000, 1'b0, 12'h800, 1'b0);
    idle();
    check("idle_o_data_hold", 32'(o_data), 32'h800);
    check("status_r5", 32'(reg_of(5)), 32'h800);

    // Reset mid-stream while a response is being held by halt.
    req(WR, 3'd4, 12'h00F, 1'b1, 12'h000, 1'b0);
    req(ST, 3'd4, 12'h3C0, 1'b1, 12'h00F, 1'b0);
    i_valid = 1'b0;
    i_halt  = 1'b1;
    step();
    check("pre_rst_status_r4", 32'(reg_of(4)), 32'h3CF);
    check("pre_rst_o_valid", 32'(o_valid), 32'd1);
    arst_n = 1'b0;
    #1;
    check("mid_rst_o_valid", 32'(o_valid), 32'd0);
    check("mid_rst_o_data", 32'(o_data), 32'd0);
    check("mid_rst_o_tag", 32'(o_tag), 32'd0);
    check("mid_rst_o_err", 32'(o_err), 32'd0);
    check("mid_rst_status", 32'(o_status != '0), 32'd0);
    step();
    step();
    arst_n = 1'b1;
    i_halt = 1'b0;
    step();
    req(RD, 3'd4, 12'h000, 1'b1, 12'h000, 1'b0);
    idle();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
